// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared framing defaults, state encoding and filter helper for the UART receiver.
package uart_rx_pkg;
  localparam int DATA_BITS_DEF = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int MID_SAMPLE_DEF = 7;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchroniser on the raw pin plus a tick-gated 3-tap majority filter.
module uart_rx_sync
  import uart_rx_pkg::*;
(
  input  logic clk_50m,
  input  logic rst,
  input  logic rx,
  input  logic rxclk_en,
  output logic rx_f
);
  logic [1:0] r_sync;
  logic [2:0] r_filt;
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_filt <= 3'b111;
    end else begin
      r_sync <= {r_sync[0], rx};
      if (rxclk_en) r_filt <= {r_filt[1:0], r_sync[1]};
    end
  end
  assign rx_f = maj3(r_filt);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver framing the filtered line on 16x ticks, with held ready/overrun flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int MID_SAMPLE = MID_SAMPLE_DEF
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rxclk_en,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  logic w_rx_f;
  logic w_done;
  rx_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [DATA_BITS-1:0] r_shreg;
  uart_rx_sync u_sync (
    .clk_50m (clk_50m),
    .rst     (rst),
    .rx      (rx),
    .rxclk_en(rxclk_en),
    .rx_f    (w_rx_f)
  );
  assign w_done = rxclk_en && r_state == ST_STOP && r_cnt == LAST;
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shreg   <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rxclk_en) begin
        r_cnt <= r_cnt + 1'b1;
        case (r_state)
          ST_IDLE: if (!w_rx_f) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
          ST_START: if (r_cnt == CW'(MID_SAMPLE)) begin
            if (w_rx_f) r_state <= ST_IDLE;
            else begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= ST_DATA;
            end
          end
          ST_DATA: if (r_cnt == LAST) begin
            r_shreg <= {w_rx_f, r_shreg[DATA_BITS-1:1]};
            r_idx   <= r_idx + 1'b1;
            if (r_idx == IW'(DATA_BITS - 1)) r_state <= ST_STOP;
          end
          ST_STOP: if (r_cnt == LAST) begin
            data      <= r_shreg;
            frame_err <= !w_rx_f;
            r_state   <= w_rx_f ? ST_IDLE : ST_BREAK;
          end
          ST_BREAK: if (w_rx_f) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
      // a completing frame beats a same-cycle clear, which only suppresses overrun
      if (w_done) begin
        rdy     <= 1'b1;
        overrun <= !rdy_clr && (rdy || overrun);
      end else if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames at 28-cycle tick spacing with per-scenario inline checks.
module tb_uart_rx;
  import uart_rx_pkg::*;
  localparam int BIT_CYC = 448;
  logic clk_50m = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rxclk_en = 1'b0;
  logic rdy_clr = 1'b0;
  logic [7:0] data;
  logic rdy, frame_err, overrun;
  int tc = 0;
  int rises = 0;
  logic rdy_q = 1'b0;
  int checks = 0;
  int passed = 0;

  uart_rx dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .rx       (rx),
    .rxclk_en (rxclk_en),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) begin
    tc       <= (tc == 27) ? 0 : tc + 1;
    rxclk_en <= (tc == 27);
    rdy_q    <= rdy;
    if (rdy && !rdy_q) rises <= rises + 1;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CYC) @(negedge clk_50m);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m);
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
    @(negedge clk_50m);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    @(negedge clk_50m);
    checks++;
    if (data !== 8'h00) $display("FAIL reset_data got %h want 00", data);
    else passed++;
    checks++;
    if (rdy !== 1'b0) $display("FAIL reset_rdy got %b want 0", rdy);
    else passed++;
    checks++;
    if (frame_err !== 1'b0) $display("FAIL reset_ferr got %b want 0", frame_err);
    else passed++;
    checks++;
    if (overrun !== 1'b0) $display("FAIL reset_ovr got %b want 0", overrun);
    else passed++;
    checks++;
    if (dut.r_state !== ST_IDLE) $display("FAIL reset_state got %0d want %0d", dut.r_state, ST_IDLE);
    else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] bytes [2] = '{8'h55, 8'hA3};
    int r0;
    for (int k = 0; k < 2; k++) begin
      r0 = rises;
      send_frame(bytes[k], 1'b1);
      checks++;
      if (rdy !== 1'b1 || data !== bytes[k]) $display("FAIL basic_rx%0d got rdy=%b data=%h want rdy=1 data=%h", k, rdy, data, bytes[k]);
      else passed++;
      checks++;
      if (frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL basic_flags%0d got ferr=%b ovr=%b want 0 0", k, frame_err, overrun);
      else passed++;
      checks++;
      if (rises !== r0 + 1) $display("FAIL basic_rises%0d got %0d want %0d", k, rises - r0, 1);
      else passed++;
      pulse_clr();
      checks++;
      if (rdy !== 1'b0 || data !== bytes[k]) $display("FAIL basic_clr%0d got rdy=%b data=%h want rdy=0 data=%h", k, rdy, data, bytes[k]);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (100) @(negedge clk_50m);
    rx = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk_50m);
    checks++;
    if (rdy !== 1'b0 || dut.r_state !== ST_IDLE) $display("FAIL glitch_ignored got rdy=%b state=%0d want rdy=0 state=0", rdy, dut.r_state);
    else passed++;
    send_frame(8'h3C, 1'b1);
    checks++;
    if (rdy !== 1'b1 || data !== 8'h3C || frame_err !== 1'b0) $display("FAIL glitch_next got rdy=%b data=%h ferr=%b want 1 3c 0", rdy, data, frame_err);
    else passed++;
    pulse_clr();
  endtask

  task automatic test_break();
    send_frame(8'h81, 1'b0);
    checks++;
    if (rdy !== 1'b1 || data !== 8'h81 || frame_err !== 1'b1) $display("FAIL break_frame got rdy=%b data=%h ferr=%b want 1 81 1", rdy, data, frame_err);
    else passed++;
    pulse_clr();
    repeat (11 * BIT_CYC) @(negedge clk_50m);
    checks++;
    if (rdy !== 1'b0 || dut.r_state !== ST_BREAK) $display("FAIL break_hold got rdy=%b state=%0d want rdy=0 state=%0d", rdy, dut.r_state, ST_BREAK);
    else passed++;
    rx = 1'b1;
    repeat (BIT_CYC) @(negedge clk_50m);
    checks++;
    if (dut.r_state !== ST_IDLE || data !== 8'h81 || frame_err !== 1'b1) $display("FAIL break_release got state=%0d data=%h ferr=%b want 0 81 1", dut.r_state, data, frame_err);
    else passed++;
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    checks++;
    if (rdy !== 1'b1 || data !== 8'h11 || overrun !== 1'b0 || frame_err !== 1'b0) $display("FAIL ovr_first got rdy=%b data=%h ovr=%b ferr=%b want 1 11 0 0", rdy, data, overrun, frame_err);
    else passed++;
    send_frame(8'h22, 1'b1);
    checks++;
    if (rdy !== 1'b1 || data !== 8'h22 || overrun !== 1'b1) $display("FAIL ovr_second got rdy=%b data=%h ovr=%b want 1 22 1", rdy, data, overrun);
    else passed++;
    pulse_clr();
    checks++;
    if (rdy !== 1'b0 || overrun !== 1'b0 || data !== 8'h22) $display("FAIL ovr_clr got rdy=%b ovr=%b data=%h want 0 0 22", rdy, overrun, data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic hit;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    repeat (BIT_CYC / 2) @(negedge clk_50m);
    rst = 1'b1;
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    repeat (BIT_CYC / 2 + 4 * BIT_CYC) @(negedge clk_50m);
    checks++;
    if (rdy !== 1'b0 || dut.r_state !== ST_IDLE) $display("FAIL rst_abort got rdy=%b state=%0d want 0 0", rdy, dut.r_state);
    else passed++;
    send_frame(8'h0F, 1'b1);
    checks++;
    if (rdy !== 1'b1 || data !== 8'h0F || overrun !== 1'b0) $display("FAIL rst_next got rdy=%b data=%h ovr=%b want 1 0f 0", rdy, data, overrun);
    else passed++;
    hit = 1'b0;
    fork
      send_frame(8'h5A, 1'b1);
      for (int i = 0; i < 12 * BIT_CYC && !hit; i++) begin
        @(negedge clk_50m);
        if (rxclk_en && dut.r_state == ST_STOP && dut.r_cnt == 4'd15) begin
          rdy_clr = 1'b1;
          hit = 1'b1;
          @(negedge clk_50m);
          rdy_clr = 1'b0;
        end
      end
    join
    checks++;
    if (hit !== 1'b1) $display("FAIL coincide_found got %b want 1", hit);
    else passed++;
    checks++;
    if (rdy !== 1'b1 || data !== 8'h5A || overrun !== 1'b0) $display("FAIL coincide got rdy=%b data=%h ovr=%b want 1 5a 0", rdy, data, overrun);
    else passed++;
    pulse_clr();
    checks++;
    if (rdy !== 1'b0) $display("FAIL coincide_clr got rdy=%b want 0", rdy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
